// File: rtl/sgd_worker_recv.sv
// Worker-side TCP receive engine: requests each notified packet from the stack, checks session
// and length, and unpacks the low NUM_OF_BANKS*32 payload bits into per-bank gradient values.
module sgd_worker_recv #(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned EXP_LEN      = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   server_session,
    input  logic                          s_axis_notifications_valid,
    output logic                          s_axis_notifications_ready,
    input  logic [31:0]                   s_axis_notifications_data,
    output logic                          m_axis_read_package_valid,
    input  logic                          m_axis_read_package_ready,
    output logic [31:0]                   m_axis_read_package_data,
    input  logic                          s_axis_rx_metadata_valid,
    output logic                          s_axis_rx_metadata_ready,
    input  logic [15:0]                   s_axis_rx_metadata_data,
    input  logic                          s_axis_rx_data_valid,
    output logic                          s_axis_rx_data_ready,
    input  logic [511:0]                  s_axis_rx_data_data,
    input  logic [63:0]                   s_axis_rx_data_keep,
    input  logic                          s_axis_rx_data_last,
    output logic [NUM_OF_BANKS-1:0][31:0] grad_out,
    output logic                          grad_out_valid,
    output logic [31:0]                   rx_pkt_cnt,
    output logic [31:0]                   rx_drop_cnt,
    output logic [31:0]                   rx_err_cnt
);

    localparam int unsigned GW         = 32 * NUM_OF_BANKS;
    localparam logic [15:0] ExpLen16   = 16'(EXP_LEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] META = 2'd2;
    localparam logic [1:0] DATA = 2'd3;

    logic [1:0]    state_q;
    logic [15:0]   sess_q;
    logic [15:0]   len_q;
    logic [15:0]   srv_q;
    logic          accept_q;
    logic          err_q;
    logic          first_q;
    logic [GW-1:0] hold_q;

    logic [15:0]   notif_len;
    logic          pkt_err;
    logic [GW-1:0] beat_banks;

    // keep and the payload above the bank lanes are intentionally not consumed
    logic unused_inputs;
    assign unused_inputs = ^{s_axis_rx_data_keep, s_axis_rx_data_data[511:GW]};

    assign notif_len  = s_axis_notifications_data[31:16];
    assign beat_banks = s_axis_rx_data_data[GW-1:0];
    // any beat beyond the first marks the packet malformed
    assign pkt_err    = err_q | ~first_q;

    always_comb begin
        s_axis_notifications_ready = ~rst && (state_q == IDLE);
        m_axis_read_package_valid  = ~rst && (state_q == REQ);
        s_axis_rx_metadata_ready   = ~rst && (state_q == META);
        s_axis_rx_data_ready       = ~rst && (state_q == DATA);
        m_axis_read_package_data   = {len_q, sess_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sess_q         <= '0;
            len_q          <= '0;
            srv_q          <= '0;
            accept_q       <= 1'b0;
            err_q          <= 1'b0;
            first_q        <= 1'b0;
            hold_q         <= '0;
            grad_out       <= '0;
            grad_out_valid <= 1'b0;
            rx_pkt_cnt     <= '0;
            rx_drop_cnt    <= '0;
            rx_err_cnt     <= '0;
        end else begin
            grad_out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_axis_notifications_valid && notif_len != 16'd0) begin
                        sess_q  <= s_axis_notifications_data[15:0];
                        len_q   <= notif_len;
                        srv_q   <= server_session;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (m_axis_read_package_ready) state_q <= META;
                end
                META: begin
                    if (s_axis_rx_metadata_valid) begin
                        accept_q <= (s_axis_rx_metadata_data == srv_q);
                        err_q    <= (len_q != ExpLen16);
                        first_q  <= 1'b1;
                        state_q  <= DATA;
                    end
                end
                default: begin
                    if (s_axis_rx_data_valid) begin
                        first_q <= 1'b0;
                        if (first_q) hold_q <= beat_banks;
                        else         err_q  <= 1'b1;
                        if (s_axis_rx_data_last) begin
                            state_q <= IDLE;
                            if (!accept_q) begin
                                rx_drop_cnt <= rx_drop_cnt + 32'd1;
                            end else if (pkt_err) begin
                                rx_err_cnt <= rx_err_cnt + 32'd1;
                            end else begin
                                grad_out       <= first_q ? beat_banks : hold_q;
                                grad_out_valid <= 1'b1;
                                rx_pkt_cnt     <= rx_pkt_cnt + 32'd1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgd_worker_recv.sv
// Directed bench for sgd_worker_recv: the bench plays both the notifying TCP stack and the
// server_session source, and checks strobes, grad values and counters against hand values.
module tb_sgd_worker_recv;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  server_session;
    logic         nv, nr;
    logic [31:0]  nd;
    logic         rv, rr;
    logic [31:0]  rd;
    logic         mv, mr;
    logic [15:0]  md;
    logic         dv, dr;
    logic [511:0] dd;
    logic [63:0]  dk;
    logic         dl;
    logic [7:0][31:0] grad_out;
    logic         grad_out_valid;
    logic [31:0]  rx_pkt_cnt, rx_drop_cnt, rx_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sgd_worker_recv #(.NUM_OF_BANKS(8), .EXP_LEN(64)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .server_session             (server_session),
        .s_axis_notifications_valid (nv),
        .s_axis_notifications_ready (nr),
        .s_axis_notifications_data  (nd),
        .m_axis_read_package_valid  (rv),
        .m_axis_read_package_ready  (rr),
        .m_axis_read_package_data   (rd),
        .s_axis_rx_metadata_valid   (mv),
        .s_axis_rx_metadata_ready   (mr),
        .s_axis_rx_metadata_data    (md),
        .s_axis_rx_data_valid       (dv),
        .s_axis_rx_data_ready       (dr),
        .s_axis_rx_data_data        (dd),
        .s_axis_rx_data_keep        (dk),
        .s_axis_rx_data_last        (dl),
        .grad_out                   (grad_out),
        .grad_out_valid             (grad_out_valid),
        .rx_pkt_cnt                 (rx_pkt_cnt),
        .rx_drop_cnt                (rx_drop_cnt),
        .rx_err_cnt                 (rx_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bank n = inc ? n+1 : v; bits above the lanes carry junk the DUT must ignore.
    function automatic logic [511:0] beat(input logic [31:0] v, input bit inc);
        logic [511:0] b;
        b = {512{1'b1}} ^ {128{4'h5}};
        for (int n = 0; n < 8; n++) b[32*n +: 32] = inc ? 32'(n + 1) : v;
        return b;
    endfunction

    // Called at a negedge with the handshake valid already driven; returns at the negedge
    // after the handshake edge.
    task automatic wait_ready(input int which, input string tag);
        bit r;
        r = 1'b0;
        for (int i = 0; i < 100 && !r; i++) begin
            #1;
            case (which)
                0:       r = nr;
                1:       r = mr;
                default: r = dr;
            endcase
            @(negedge clk);
        end
        check({tag, "_handshake"}, 256'(r), 256'd1);
    endtask

    task automatic send_notif(input logic [15:0] len, input logic [15:0] sess);
        nv = 1'b1;
        nd = {len, sess};
        wait_ready(0, "notif");
        nv = 1'b0;
    endtask

    // Act as the stack for one packet; nbeats == 0 stops once the DUT is in its data phase.
    task automatic serve(input logic [15:0] len, input logic [15:0] sess, input logic [15:0] msess,
                         input int nbeats, input logic [511:0] b0, input logic [511:0] b1,
                         input bit strobe, input bit stall);
        int k;
        bit got;
        logic [511:0] e;
        k   = stall ? int'($urandom_range(0, 3)) : 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (rv) begin
                if (k == 0) begin
                    rr  = 1'b1;
                    got = 1'b1;
                    check("read_req", 256'(rd), 256'({len, sess}));
                end else begin
                    k--;
                end
            end
            @(negedge clk);
        end
        rr = 1'b0;
        check("read_req_seen", 256'(got), 256'd1);
        if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
        mv = 1'b1;
        md = msess;
        wait_ready(1, "meta");
        mv = 1'b0;
        if (nbeats == 0) return;
        for (int b = 0; b < nbeats; b++) begin
            if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
            dv = 1'b1;
            dd = (b == 0) ? b0 : b1;
            dl = (b == nbeats - 1);
            wait_ready(2, "data");
            dv = 1'b0;
            dl = 1'b0;
        end
        check("strobe", 256'(grad_out_valid), 256'(strobe));
        check("idle_after_last", 256'(nr), 256'd1);
        if (strobe) begin
            e = b0;
            check("grad_out", grad_out, e[255:0]);
        end
        @(negedge clk);
        check("strobe_one_cycle", 256'(grad_out_valid), 256'd0);
    endtask

    initial begin : stim
        logic [511:0] inc_b;
        logic [511:0] b_neg, b_max, b_zero;
        bit seen;
        inc_b  = beat(32'h0, 1'b1);
        b_neg  = beat(32'hFFFF_FFFF, 1'b0);
        b_max  = beat(32'h7FFF_FFFF, 1'b0);
        b_zero = beat(32'h0, 1'b0);
        rst = 1'b1; server_session = 16'd3;
        nv = 0; nd = 0; rr = 0; mv = 0; md = 0; dv = 0; dd = 0; dk = '1; dl = 0;
        repeat (2) @(negedge clk);
        check("rst_notif_ready", 256'(nr), 256'd0);
        check("rst_valid", 256'(grad_out_valid), 256'd0);
        check("rst_grad", grad_out, 256'd0);
        check("rst_cnts", 256'({rx_pkt_cnt, rx_drop_cnt, rx_err_cnt}), 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // zero-length notification is swallowed
        send_notif(16'd0, 16'd3);
        seen = 1'b0;
        repeat (5) begin
            #1; seen |= rv;
            @(negedge clk);
        end
        check("len0_no_req", 256'(seen), 256'd0);
        check("len0_idle", 256'(nr), 256'd1);
        check("len0_cnts", 256'({rx_pkt_cnt, rx_drop_cnt, rx_err_cnt}), 256'd0);

        // accepted single-beat packet
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 1, inc_b, inc_b, 1'b1, 1'b0);
        check("pkt_cnt_1", 256'(rx_pkt_cnt), 256'd1);

        // foreign session
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd5, 1, b_neg, b_neg, 1'b0, 1'b0);
        check("drop_cnt", 256'(rx_drop_cnt), 256'd1);
        check("grad_kept_drop", grad_out, inc_b[255:0]);

        // two-beat, wrong length
        send_notif(16'd128, 16'd3);
        serve(16'd128, 16'd3, 16'd3, 2, b_neg, b_zero, 1'b0, 1'b0);
        check("err_cnt", 256'(rx_err_cnt), 256'd1);
        check("grad_kept_err", grad_out, inc_b[255:0]);
        check("pkt_cnt_still_1", 256'(rx_pkt_cnt), 256'd1);

        // back-to-back with random stack stalls
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 1, b_neg, b_neg, 1'b1, 1'b1);
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 1, b_max, b_max, 1'b1, 1'b1);
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 1, b_zero, b_zero, 1'b1, 1'b1);
        check("pkt_cnt_4", 256'(rx_pkt_cnt), 256'd4);
        check("drop_err_stable", 256'({rx_drop_cnt, rx_err_cnt}), 256'({32'd1, 32'd1}));

        // reset while in the data phase
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 0, inc_b, inc_b, 1'b0, 1'b0);
        #1;
        check("in_data", 256'(dr), 256'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_cnts", 256'({rx_pkt_cnt, rx_drop_cnt, rx_err_cnt}), 256'd0);
        check("mid_rst_grad", grad_out, 256'd0);
        check("mid_rst_hs", 256'({grad_out_valid, rv, mr, dr}), 256'd0);
        check("mid_rst_idle", 256'(nr), 256'd1);
        @(negedge clk);
        send_notif(16'd64, 16'd3);
        serve(16'd64, 16'd3, 16'd3, 1, inc_b, inc_b, 1'b1, 1'b0);
        check("post_rst_pkt", 256'(rx_pkt_cnt), 256'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sgd_worker_recv.md
Name: sgd_worker_recv

Overview:
- Worker-side TCP receive engine; the receiving end of the server's per-worker gradient broadcast.
- Consumes TCP stack notifications, issues read-package requests, and accepts rx metadata and rx data.
- Unpacks the low NUM_OF_BANKS*32 bits of the first payload beat into per-bank signed 32-bit values for the worker's model-update stage.
- Drops packets from foreign sessions and malformed packets, and counts them.

Parameters:
- NUM_OF_BANKS, 8, number of 32-bit bank lanes unpacked from the payload.
- EXP_LEN, 64, expected payload length in bytes (one 512-bit beat).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- server_session  input  16  session ID of the server connection; sampled on every notification.
- s_axis_notifications  axis_meta.slave  -  data[15:0] session, data[31:16] length in bytes.
- m_axis_read_package  axis_meta.master  -  data[15:0] session, data[31:16] length.
- s_axis_rx_metadata  axis_meta.slave  -  data[15:0] session.
- s_axis_rx_data  axi_stream.slave  -  512-bit data, keep, last.
- grad_out  output  [NUM_OF_BANKS-1:0][31:0] signed  unpacked bank values.
- grad_out_valid  output  1  one-cycle strobe marking grad_out valid.
- rx_pkt_cnt  output  32  accepted packets.
- rx_drop_cnt  output  32  packets dropped for session mismatch.
- rx_err_cnt  output  32  packets with length != EXP_LEN or more than one beat.

Behaviour:
- Reset values (synchronous, rst=1): state=IDLE, grad_out=0, grad_out_valid=0, all counters=0, all valid/ready outputs=0. Reset mid-packet aborts to IDLE; the remaining stack beats are not drained.
- Notification handling:
  - s_axis_notifications.ready=1 only in IDLE.
  - A notification with length==0 is consumed and ignored; state stays IDLE.
- State IDLE: on notification handshake with length!=0, latch session and length, then go to REQ.
- State REQ:
  - m_axis_read_package.valid=1 with the latched {length,session}.
  - On handshake go to META. Valid is held stable until ready.
- State META:
  - s_axis_rx_metadata.ready=1.
  - On handshake set the accept flag = (metadata session==server_session) and set the err flag = (latched length!=EXP_LEN), then go to DATA.
- State DATA:
  - s_axis_rx_data.ready=1 continuously.
  - First beat: capture data[32*NUM_OF_BANKS-1:0] into a holding register, with bank n = bits [32n+31:32n].
  - Every beat after the first sets the err flag.
  - On the beat with last=1, go to IDLE and resolve the packet:
    - accept & ~err: grad_out is loaded from the holding register (or from the current beat if the packet is single-beat); grad_out_valid=1 the cycle after the last handshake, for exactly one cycle; rx_pkt_cnt+1.
    - ~accept: rx_drop_cnt+1; no strobe. This takes priority over err.
    - accept & err: rx_err_cnt+1; no strobe.
- Output timing:
  - grad_out holds its value until the next accepted packet.
  - No downstream backpressure; the consumer must take the data on the strobe.
- Minimum per-packet occupancy is 4 cycles (IDLE, REQ, META, DATA). A notification arriving during a busy state is stalled via ready=0, never lost.
- keep is ignored.
- Counters wrap at 2^32.
- Back-to-back packets: IDLE is re-entered in the cycle after last, and the next notification may handshake in that cycle.

Test Plan:
- Notification {len=64, sess=3} with server_session=3; metadata sess=3; one beat with bank n = n+1 and last=1 -> read request {64,3} issued; grad_out[n]=n+1; grad_out_valid high for 1 cycle, 1 cycle after last; rx_pkt_cnt=1.
- Same sequence with metadata sess=5 -> no strobe; rx_drop_cnt=1; grad_out unchanged.
- len=128, two beats (first beat bank values 0xFFFF_FFFF) -> both beats consumed; rx_err_cnt=1; no strobe.
- Notification len=0 -> no read request; state returns to IDLE; all counters 0.
- Three back-to-back valid packets with stack ready deasserted randomly -> three strobes in order, carrying values -1, 0x7FFF_FFFF, 0; rx_pkt_cnt=3; no handshake lost.
- rst asserted for 1 cycle during DATA -> all outputs 0 next cycle; the next full packet is received correctly.
